rmt_ctrl_arbiter: RTL and testbench

RMT_CTRL_ARBITER -- requirements
Module: rmt_ctrl_arbiter

---
 rtl/rmt_ctrl_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_rmt_ctrl_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_ctrl_arbiter.sv
// rmt_ctrl_arbiter: merges two AXI-Stream control sources into the parser
// control input, one whole packet at a time, with round-robin choice on
// contention and a fixed one-cycle forwarding latency.
// Optional stall watchdog: define RMT_CTRL_ARB_TIMEOUT_EN to compile it in.
module rmt_ctrl_arbiter #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned TIMEOUT_CYCLES       = 256
) (
  input  logic                              clk,
  input  logic                              aresetn,
  // source 0: packet filter
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,
  // source 1: host injection
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,
  // merged control stream (no backpressure)
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [1:0]                        grant,
  output logic [15:0]                       abort_cnt
);

  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t          r_state;
  logic [1:0]      r_grant;
  logic [1:0]      r_last_grant;
  logic [DW-1:0]   r_tdata;
  logic [KW-1:0]   r_tkeep;
  logic [UW-1:0]   r_tuser;
  logic            r_tvalid;
  logic            r_tlast;

  logic [1:0]      w_pick;
  logic [DW-1:0]   w_sel_tdata;
  logic [KW-1:0]   w_sel_tkeep;
  logic [UW-1:0]   w_sel_tuser;
  logic            w_sel_tvalid;
  logic            w_sel_tlast;
  logic            w_acc;
  logic            w_timeout;

  // Ready goes only to the owner, and only while a packet is in progress
  assign s0_axis_tready = (r_state != IDLE) && r_grant[0];
  assign s1_axis_tready = (r_state != IDLE) && r_grant[1];

  assign c_m_axis_tdata  = r_tdata;
  assign c_m_axis_tkeep  = r_tkeep;
  assign c_m_axis_tuser  = r_tuser;
  assign c_m_axis_tvalid = r_tvalid;
  assign c_m_axis_tlast  = r_tlast;
  assign grant           = r_grant;

  // Owner's beat, selected by the current grant
  always_comb begin
    w_sel_tdata  = s0_axis_tdata;
    w_sel_tkeep  = s0_axis_tkeep;
    w_sel_tuser  = s0_axis_tuser;
    w_sel_tvalid = s0_axis_tvalid;
    w_sel_tlast  = s0_axis_tlast;
    if (r_grant[1]) begin
      w_sel_tdata  = s1_axis_tdata;
      w_sel_tkeep  = s1_axis_tkeep;
      w_sel_tuser  = s1_axis_tuser;
      w_sel_tvalid = s1_axis_tvalid;
      w_sel_tlast  = s1_axis_tlast;
    end
  end

  // Ready is implied for the owner outside IDLE, so valid alone means accepted
  assign w_acc = (r_state != IDLE) && w_sel_tvalid;

  // Source choice in IDLE: sole requester wins, otherwise the one not served last
  always_comb begin
    w_pick = 2'b00;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      w_pick = (r_last_grant == 2'b01) ? 2'b10 : 2'b01;
    end else if (s0_axis_tvalid) begin
      w_pick = 2'b01;
    end else if (s1_axis_tvalid) begin
      w_pick = 2'b10;
    end
  end

`ifdef RMT_CTRL_ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_stall;
  logic [15:0] r_abort_cnt;

  assign w_timeout = (r_state == BUSY) && (r_stall == LP_TIMEOUT);
  assign abort_cnt = r_abort_cnt;

  // Consecutive BUSY cycles without an accepted beat; held at the limit
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_stall <= '0;
    end else if ((r_state != BUSY) || w_acc || w_timeout) begin
      r_stall <= '0;
    end else if (r_stall != LP_TIMEOUT) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  // Saturating count of packets cut short by the watchdog
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_abort_cnt <= '0;
    end else if (w_timeout && (r_abort_cnt != '1)) begin
      r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign abort_cnt        = '0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Packet-level arbitration FSM with registered one-cycle forwarding
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= 2'b10;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tuser      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
    end else begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick != 2'b00) begin
            r_state <= BUSY;
            r_grant <= w_pick;
          end
        end
        BUSY: begin
          if (w_timeout) begin
            // Watchdog wins over any beat accepted this cycle: that beat is dropped
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tuser  <= '0;
            if (w_acc && w_sel_tlast) begin
              r_state      <= IDLE;
              r_grant      <= '0;
              r_last_grant <= r_grant;
            end else begin
              r_state <= DRAIN;
            end
          end else if (w_acc) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_sel_tlast;
            r_tdata  <= w_sel_tdata;
            r_tkeep  <= w_sel_tkeep;
            r_tuser  <= w_sel_tuser;
            if (w_sel_tlast) begin
              r_state      <= IDLE;
              r_grant      <= '0;
              r_last_grant <= r_grant;
            end
          end
        end
        DRAIN: begin
          if (w_acc && w_sel_tlast) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= r_grant;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmt_ctrl_arbiter.sv
// Self-checking bench for rmt_ctrl_arbiter: expected beats are queued in
// arbitration order by the test sequence and popped as the DUT emits them.
module tb_rmt_ctrl_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned UW = 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b1;
  logic [DW-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic [KW-1:0] s0_axis_tkeep = '0, s1_axis_tkeep = '0;
  logic [UW-1:0] s0_axis_tuser = '0, s1_axis_tuser = '0;
  logic          s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic          s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
  logic          s0_axis_tready, s1_axis_tready;
  logic [DW-1:0] c_m_axis_tdata;
  logic [KW-1:0] c_m_axis_tkeep;
  logic [UW-1:0] c_m_axis_tuser;
  logic          c_m_axis_tvalid, c_m_axis_tlast;
  logic [1:0]    grant;
  logic [15:0]   abort_cnt;

  rmt_ctrl_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .TIMEOUT_CYCLES      (TO)
  ) u_dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tuser  (s0_axis_tuser),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tuser  (s1_axis_tuser),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .c_m_axis_tdata (c_m_axis_tdata),
    .c_m_axis_tkeep (c_m_axis_tkeep),
    .c_m_axis_tuser (c_m_axis_tuser),
    .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tlast (c_m_axis_tlast),
    .grant          (grant),
    .abort_cnt      (abort_cnt)
  );

  always #5 clk = ~clk;

  int unsigned  n_chk  = 0;
  int unsigned  n_fail = 0;
  int           cyc    = 0;
  logic [44:0]  exp_q[$];
  int           out_t[$];
  logic [44:0]  w_out;

  assign w_out = {c_m_axis_tdata, c_m_axis_tkeep, c_m_axis_tuser, c_m_axis_tlast};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Beat image {tdata, tkeep, tuser, tlast}; tkeep narrows on the last beat
  function automatic logic [44:0] mk(input int src, input logic [7:0] id, input int b, input int n);
    logic lst;
    lst = (b == n - 1);
    mk = {8'(src + 1), id, 8'(b), 8'h3C, (lst ? 4'h3 : 4'hF), id[3:0], 4'(b), lst};
  endfunction

  task automatic push_pkt(input int src, input logic [7:0] id, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(src, id, b, n));
  endtask

  task automatic drive(input int src, input logic v, input logic [44:0] bt);
    if (src == 0) begin
      s0_axis_tvalid = v;
      {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast} = bt;
    end else begin
      s1_axis_tvalid = v;
      {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast} = bt;
    end
  endtask

  // Called at a negedge; each beat is held until ready is seen before a rising edge
  task automatic send(input int src, input int n, input logic [7:0] id,
                      input int gap_after, input int gap_len);
    for (int b = 0; b < n; b++) begin
      logic [44:0] bt;
      logic        rdy;
      int          w;
      bt = mk(src, id, b, n);
      drive(src, 1'b1, bt);
      w = 0;
      forever begin
        rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
        @(negedge clk);
        if (rdy) break;
        w++;
        if (w > 200) begin
          chk("handshake_wait", 64'(w), 64'h0);
          break;
        end
      end
      drive(src, 1'b0, bt);
      if (b + 1 == gap_after) repeat (gap_len) @(negedge clk);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (c_m_axis_tvalid) begin
      out_t.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_unexpected_beat", 64'(w_out), 64'h0);
      else chk("sb_beat", 64'(w_out), 64'(exp_q.pop_front()));
    end else begin
      chk("idle_tlast", 64'(c_m_axis_tlast), 64'h0);
    end
    chk("ready_exclusive", 64'(s0_axis_tready & s1_axis_tready), 64'h0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0;
    int src;
    int n;
    #1 aresetn = 1'b0;
    #1;
    chk("rst_out", 64'({w_out, c_m_axis_tvalid}), 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_ready", 64'({s0_axis_tready, s1_axis_tready}), 64'h0);
    chk("rst_abort", 64'(abort_cnt), 64'h0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // Contention right after reset: s0 first, then s1, then s0's second packet
    push_pkt(0, 8'h01, 3);
    push_pkt(1, 8'h02, 2);
    push_pkt(0, 8'h03, 2);
    out_t.delete();
    fork
      begin send(0, 3, 8'h01, 0, 0); send(0, 2, 8'h03, 0, 0); end
      send(1, 2, 8'h02, 0, 0);
    join
    repeat (3) @(negedge clk);
    if (out_t.size() == 7) begin
      chk("rr_gap_s0_s1", 64'(out_t[3] - out_t[2]), 64'd2);
      chk("rr_gap_s1_s0", 64'(out_t[5] - out_t[4]), 64'd2);
    end else chk("rr_beat_count", 64'(out_t.size()), 64'd7);

    // 3-beat s0 packet, s1 idle: latency and grant timing
    push_pkt(0, 8'h04, 3);
    out_t.delete();
    t0 = cyc;
    fork
      send(0, 3, 8'h04, 0, 0);
      begin
        @(negedge clk);
        chk("p3_grant_busy", 64'(grant), 64'h1);
        repeat (2) @(negedge clk);
        chk("p3_grant_last", 64'(grant), 64'h1);
        @(negedge clk);
        chk("p3_grant_done", 64'(grant), 64'h0);
      end
    join
    repeat (2) @(negedge clk);
    if (out_t.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("p3_latency", 64'(out_t[i] - t0), 64'(2 + i));
    end else chk("p3_beat_count", 64'(out_t.size()), 64'd3);

    // s1 stalls 5 cycles mid-packet while s0 waits
    push_pkt(1, 8'h05, 4);
    push_pkt(0, 8'h06, 2);
    out_t.delete();
    fork
      send(1, 4, 8'h05, 2, 5);
      begin @(negedge clk); send(0, 2, 8'h06, 0, 0); end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("gap_s0_ready_low", 64'(s0_axis_tready), 64'h0);
        end
      end
    join
    repeat (2) @(negedge clk);
    if (out_t.size() == 6) chk("gap_len", 64'(out_t[2] - out_t[1]), 64'd6);
    else chk("gap_beat_count", 64'(out_t.size()), 64'd6);

    // Single-beat and short packets, alternating sources
    for (int i = 0; i < 6; i++) begin
      src = i % 2;
      n   = (i < 2) ? 1 : int'($urandom_range(1, 4));
      push_pkt(src, 8'(8'h10 + i), n);
      send(src, n, 8'(8'h10 + i), 0, 0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

`ifdef RMT_CTRL_ARB_TIMEOUT_EN
    // s0 stalls after beat 1: abort beat, rest of s0 discarded, then s1
    exp_q.push_back(mk(0, 8'h20, 0, 4));
    exp_q.push_back(45'h1);
    push_pkt(1, 8'h21, 2);
    fork
      send(0, 4, 8'h20, 1, 12);
      begin @(negedge clk); send(1, 2, 8'h21, 0, 0); end
    join
    repeat (3) @(negedge clk);
    chk("timeout_abort_cnt", 64'(abort_cnt), 64'd1);
`else
    // Long stall: no watchdog, packet completes and s1 follows
    push_pkt(0, 8'h20, 3);
    push_pkt(1, 8'h21, 2);
    fork
      send(0, 3, 8'h20, 1, 40);
      begin @(negedge clk); send(1, 2, 8'h21, 0, 0); end
    join
    repeat (3) @(negedge clk);
    chk("stall_abort_cnt", 64'(abort_cnt), 64'd0);
`endif

    // Reset on the 2nd beat of a 4-beat packet
    exp_q.push_back(mk(0, 8'h30, 0, 4));
    drive(0, 1'b1, mk(0, 8'h30, 0, 4));
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b1, mk(0, 8'h30, 1, 4));
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_out", 64'({w_out, c_m_axis_tvalid}), 64'h0);
    chk("mid_rst_grant", 64'(grant), 64'h0);
    chk("mid_rst_ready", 64'({s0_axis_tready, s1_axis_tready}), 64'h0);
    drive(0, 1'b0, mk(0, 8'h30, 1, 4));
    @(negedge clk);
    aresetn = 1'b1;
    chk("mid_rst_abort", 64'(abort_cnt), 64'h0);
    push_pkt(1, 8'h31, 3);
    send(1, 3, 8'h31, 0, 0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
